wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that produces the single write port (W_en / Rd / Wr_data) of the integer register file from two result sources: the single-cycle ALU path and the multi-cycle load/store unit (LSU). It buffers LSU results in a small FIFO, arbitrates with an anti-starvation counter, and keeps a pending-load scoreboard. Issue logic queries the scoreboard to stall on RAW/WAW hazards against in-flight loads.

## Interface
- FIFO_DEPTH, 2, LSU result buffer entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive cycles an LSU head entry may lose arbitration before it is forced through
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_stall  output  1  ALU result not taken this cycle; producer holds alu_* stable
- lsu_valid  input  1  LSU result offered
- lsu_ready  output  1  FIFO can accept (count < FIFO_DEPTH)
- lsu_rd  input  5  load destination register
- lsu_data  input  32  load data
- ld_issue  input  1  a load is issued this cycle
- ld_rd  input  5  destination register of the issued load
- q_rs1, q_rs2  input  5 each  scoreboard query addresses
- q_busy1, q_busy2  output  1 each  queried register has a load pending (combinational)
- W_en  output  1  register-file write enable (registered)
- Rd  output  5  register-file write address (registered)
- Wr_data  output  32  register-file write data (registered)

## Operation
- LSU handshake: entry accepted when lsu_valid & lsu_ready; pushed to FIFO tail. lsu_ready is combinational from count only; no dependence on lsu_valid.
- Arbitration each cycle, in priority order:
  1. FIFO non-empty and starve counter == STARVE_MAX: pop LSU head, assert alu_stall if alu_valid.
  2. alu_valid: take ALU.
  3. FIFO non-empty: pop LSU head.
  4. Otherwise: no write.
- Starve counter: increments (saturating) each cycle the FIFO is non-empty and the head is not popped. Clears on any pop and whenever the FIFO is empty.
- Selected source is registered into W_en/Rd/Wr_data with a companion flag wr_lsu. When nothing is selected, W_en=0 and Rd/Wr_data hold their previous values.
- Selected rd == 0: W_en stays 0. The slot is still consumed (ALU taken / FIFO popped).
- Scoreboard: 32-bit pending vector.
  - Set bit ld_rd on ld_issue when ld_rd != 0.
  - Clear bit Rd on the edge where W_en & wr_lsu is high, i.e. the same edge the register file commits the data.
  - Bit 0 is always 0.
  - Set and clear of the same bit on the same edge: set wins.
- q_busyN = pending[q_rsN]; q_rsN == 0 always reads 0.
- Issuing a load to an already-pending rd, or an ALU write to a pending rd, is a caller violation (caller must stall on q_busy). No internal detection.
- Simultaneous push and pop: both happen, count unchanged. Push while full cannot occur (lsu_ready=0).

## Timing
- Reset (asynchronous, any cycle including mid-transfer): W_en=0, Rd=0, Wr_data=0, wr_lsu=0, pending=0, FIFO empty, starve counter=0. Hence lsu_ready=1, q_busy*=0, alu_stall=0. Entries in flight are discarded.
- ALU result at cycle N → W_en/Rd/Wr_data at N+1; register file updated at end of N+1.
- LSU accepted at N → earliest W_en at N+2; pending bit clears at end of N+2; q_busy low from N+3.
- alu_stall is combinational in the same cycle as alu_valid. The ALU is taken no later than the cycle after the stall, since the counter clears on the forced pop.
- Throughput: one register-file write per cycle maximum.

## Test plan
- Reset then alu_valid=1, alu_rd=5, alu_data=0x1234 at cycle 1 → W_en=1, Rd=5, Wr_data=0x1234 at cycle 2; alu_stall never asserted.
- ld_issue with ld_rd=7 at cycle 1, LSU returns rd=7, data=0xDEADBEEF at cycle 4 with no ALU traffic → q_busy(7)=1 for cycles 2–6, W_en=1 Rd=7 at cycle 6, q_busy(7)=0 at cycle 7.
- ALU valid every cycle and one LSU entry pushed at cycle 1, STARVE_MAX=4 → LSU write appears at cycle 7, alu_stall high at cycle 6 only, held ALU result written at cycle 8.
- Three LSU pushes back-to-back with ALU continuously valid, FIFO_DEPTH=2 → lsu_ready=0 after second push; third entry accepted only after first forced pop; all three written in order.
- alu_rd=0 with data 0xFFFFFFFF, and ld_issue with ld_rd=0 → W_en stays 0 and q_busy for reg 0 stays 0.
- Assert rst mid-operation with FIFO holding 2 entries and pending bits 3 and 9 set → immediately W_en=0, lsu_ready=1, q_busy for 3 and 9 = 0; no write of the discarded entries after rst drops.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and buffered LSU results into
// one register-file write port, with anti-starvation and a pending-load scoreboard.
module wb_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_stall,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   input  logic        ld_issue,
   input  logic [4:0]  ld_rd,
   input  logic [4:0]  q_rs1,
   input  logic [4:0]  q_rs2,
   output logic        q_busy1,
   output logic        q_busy2,
   output logic        W_en,
   output logic [4:0]  Rd,
   output logic [31:0] Wr_data
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [4:0]    fifo_rd   [FIFO_DEPTH];
   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic [SW-1:0] starve;
   logic [SW-1:0] starve_next;
   logic [31:0]   pending;
   logic [31:0]   set_vec;
   logic [31:0]   clr_vec;
   logic          wr_lsu;
   logic          fifo_empty;
   logic          forced;
   logic          push;
   logic          pop;
   logic          sel_valid;
   logic          sel_lsu;
   logic [4:0]    sel_rd;
   logic [31:0]   sel_data;

   assign fifo_empty = (count == {CW{1'b0}});
   assign lsu_ready  = (count != FULL_CNT);
   assign push       = lsu_valid & lsu_ready;
   assign forced     = !fifo_empty && (starve == STARVE_LIM);

   // Source selection: starving LSU head first, then ALU, then LSU.
   always_comb begin
      pop       = 1'b0;
      alu_stall = 1'b0;
      sel_valid = 1'b0;
      sel_lsu   = 1'b0;
      sel_rd    = fifo_rd[head];
      sel_data  = fifo_data[head];
      if (forced) begin
         pop       = 1'b1;
         sel_valid = 1'b1;
         sel_lsu   = 1'b1;
         alu_stall = alu_valid;
      end else if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (!fifo_empty) begin
         pop       = 1'b1;
         sel_valid = 1'b1;
         sel_lsu   = 1'b1;
      end else begin
         sel_valid = 1'b0;
      end
   end

   // Starve counter: clears on pop or empty, otherwise saturating increment.
   always_comb begin
      starve_next = starve;
      if (pop || fifo_empty) begin
         starve_next = {SW{1'b0}};
      end else if (starve != STARVE_LIM) begin
         starve_next = starve + {{(SW-1){1'b0}}, 1'b1};
      end else begin
         starve_next = starve;
      end
   end

   // Scoreboard update vectors; a same-edge set overrides the clear.
   always_comb begin
      set_vec = 32'h0000_0000;
      clr_vec = 32'h0000_0000;
      if (ld_issue) begin
         set_vec = 32'h0000_0001 << ld_rd;
      end else begin
         set_vec = 32'h0000_0000;
      end
      if (W_en && wr_lsu) begin
         clr_vec = 32'h0000_0001 << Rd;
      end else begin
         clr_vec = 32'h0000_0000;
      end
   end

   // FIFO storage, written at the tail on each accepted LSU result.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[tail]   <= lsu_rd;
         fifo_data[tail] <= lsu_data;
      end
   end

   // FIFO pointers, occupancy, starve counter and scoreboard state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= {AW{1'b0}};
         tail    <= {AW{1'b0}};
         count   <= {CW{1'b0}};
         starve  <= {SW{1'b0}};
         pending <= 32'h0000_0000;
      end else begin
         if (push) tail <= tail + {{(AW-1){1'b0}}, 1'b1};
         if (pop)  head <= head + {{(AW-1){1'b0}}, 1'b1};
         case ({push, pop})
            2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
            default: count <= count;
         endcase
         starve  <= starve_next;
         pending <= ((pending & ~clr_vec) | set_vec) & ~32'h0000_0001;
      end
   end

   // Registered write port; writes to x0 consume the slot but never enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         W_en    <= 1'b0;
         Rd      <= 5'd0;
         Wr_data <= 32'h0000_0000;
         wr_lsu  <= 1'b0;
      end else if (sel_valid) begin
         W_en    <= (sel_rd != 5'd0);
         Rd      <= sel_rd;
         Wr_data <= sel_data;
         wr_lsu  <= sel_lsu;
      end else begin
         W_en    <= 1'b0;
         wr_lsu  <= 1'b0;
      end
   end

   assign q_busy1 = (q_rs1 != 5'd0) && pending[q_rs1];
   assign q_busy2 = (q_rs2 != 5'd0) && pending[q_rs2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_wb_arbiter;

   localparam int FIFO_DEPTH = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        q_busy1;
   logic        q_busy2;
   logic        W_en;
   logic [4:0]  Rd;
   logic [31:0] Wr_data;

   wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .ld_issue(ld_issue), .ld_rd(ld_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2),
      .W_en(W_en), .Rd(Rd), .Wr_data(Wr_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   // Reference model state
   ent_t        mq[$];
   int          m_starve;
   bit          m_pend[32];
   bit          m_wen;
   bit          m_wlsu;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   bit          last_stall;
   bit          last_acc;
   int          n_cmp = 0;
   int          n_err = 0;
   int          stall_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_starve = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_wen = 1'b0; m_wlsu = 1'b0; m_rd = 5'd0; m_data = 32'h0;
      last_stall = 1'b0;
      last_acc = 1'b0;
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
      ld_issue = 1'b0; ld_rd = 5'd0;
   endtask

   // One clock: check combinational outputs, advance the model, check the write port.
   task automatic step();
      bit          fr, sel, slsu, acc;
      logic [4:0]  srd;
      logic [31:0] sdat;
      #2;
      fr = (mq.size() > 0) && (m_starve >= STARVE_MAX);
      chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, mq.size() < FIFO_DEPTH});
      chk("alu_stall", {31'b0, alu_stall}, {31'b0, fr && alu_valid});
      chk("q_busy1", {31'b0, q_busy1}, {31'b0, (q_rs1 != 5'd0) && m_pend[q_rs1]});
      chk("q_busy2", {31'b0, q_busy2}, {31'b0, (q_rs2 != 5'd0) && m_pend[q_rs2]});
      acc = lsu_valid && (mq.size() < FIFO_DEPTH);
      sel = 1'b0; slsu = 1'b0; srd = 5'd0; sdat = 32'h0;
      if (fr || (!alu_valid && mq.size() > 0)) begin
         sel = 1'b1; slsu = 1'b1; srd = mq[0].rd; sdat = mq[0].data;
      end else if (alu_valid) begin
         sel = 1'b1; srd = alu_rd; sdat = alu_data;
      end
      if (slsu || mq.size() == 0) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      if (m_wen && m_wlsu) m_pend[m_rd] = 1'b0;
      if (ld_issue && ld_rd != 5'd0) m_pend[ld_rd] = 1'b1;
      if (slsu) void'(mq.pop_front());
      if (acc) mq.push_back('{rd: lsu_rd, data: lsu_data});
      last_stall = fr && alu_valid;
      last_acc = acc;
      if (last_stall) stall_cnt++;
      m_wen  = sel && (srd != 5'd0);
      m_wlsu = sel && slsu;
      if (sel) begin m_rd = srd; m_data = sdat; end
      @(posedge clk); #1;
      chk("W_en", {31'b0, W_en}, {31'b0, m_wen});
      if (m_wen) begin
         chk("Rd", {27'b0, Rd}, {27'b0, m_rd});
         chk("Wr_data", Wr_data, m_data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      idle();
      q_rs1 = 5'd0; q_rs2 = 5'd0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_W_en", {31'b0, W_en}, 32'd0);
      chk("rst_Rd", {27'b0, Rd}, 32'd0);
      chk("rst_Wr_data", Wr_data, 32'd0);
      chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
      chk("rst_alu_stall", {31'b0, alu_stall}, 32'd0);
      rst = 1'b0;

      // ALU write appears one cycle later
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
      step();
      chk("alu_first_Rd", {27'b0, Rd}, 32'd5);
      chk("alu_first_data", Wr_data, 32'h0000_1234);
      idle(); step();

      // Load to r7: busy until the LSU write commits
      q_rs1 = 5'd7; q_rs2 = 5'd3;
      ld_issue = 1'b1; ld_rd = 5'd7; step();
      idle(); step(); step();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEAD_BEEF; step();
      idle();
      for (int i = 0; i < 4; i++) step();
      chk("busy7_cleared", {31'b0, q_busy1}, 32'd0);

      // Continuous ALU with one LSU entry: exactly one forced pop and one stall
      stall_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (!last_stall) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000_0000 + i;
         end
         lsu_valid = (i == 0); lsu_rd = 5'd12; lsu_data = 32'h0BAD_F00D;
         step();
      end
      chk("starve_stall_count", stall_cnt, 32'd1);

      // Three back-to-back LSU pushes against continuous ALU traffic
      k = 0;
      for (int i = 0; i < 30; i++) begin
         if (!last_stall) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + (i % 30)); alu_data = 32'hC000_0000 + i;
         end
         lsu_valid = (k < 3); lsu_rd = 5'(20 + k); lsu_data = 32'h5000_0000 + k;
         step();
         if (last_acc) k++;
      end
      chk("three_pushes_accepted", k, 32'd3);
      idle(); step(); step();

      // Writes and loads to x0 never enable or mark busy
      q_rs1 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
      ld_issue = 1'b1; ld_rd = 5'd0;
      step();
      idle(); step();
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1111_1111; step();
      idle(); step(); step();

      // Reset mid-operation with a full FIFO and loads pending to r3, r9
      q_rs1 = 5'd3; q_rs2 = 5'd9;
      ld_issue = 1'b1; ld_rd = 5'd3; step();
      ld_rd = 5'd9; step();
      ld_issue = 1'b0;
      for (int i = 0; i < 2; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(14 + i); alu_data = 32'h7000_0000 + i;
         lsu_valid = 1'b1; lsu_rd = 5'(3 + 6 * i); lsu_data = 32'h3300_0000 + i;
         step();
      end
      alu_rd = 5'd16; lsu_valid = 1'b0;
      rst = 1'b1; #1;
      model_reset();
      chk("midrst_W_en", {31'b0, W_en}, 32'd0);
      chk("midrst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
      chk("midrst_busy3", {31'b0, q_busy1}, 32'd0);
      chk("midrst_busy9", {31'b0, q_busy2}, 32'd0);
      idle();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // Random traffic; ALU inputs held while stalled
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
         end
         lsu_valid = ($urandom_range(0, 99) < 40);
         lsu_rd    = 5'($urandom_range(0, 31));
         lsu_data  = $urandom;
         ld_issue  = ($urandom_range(0, 99) < 30);
         ld_rd     = 5'($urandom_range(0, 31));
         q_rs1     = 5'($urandom_range(0, 31));
         q_rs2     = 5'($urandom_range(0, 31));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
